// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU issue controller: state encoding,
// default latencies and the M-extension funct3 decode.
package mdu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 33;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // DIV/DIVU/REM/REMU all have funct3[2] set; MUL* never do.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction
endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// EXE/ID-side bundle of the MDU issue controller. The pipeline drives
// through the master modport; the controller sits on the slave modport.
interface mdu_issue_ctrl_if;
    logic       issue_valid_EXE;
    logic       op_is_div_EXE;
    logic       divisor_zero_EXE;
    logic       kill_EXE;
    logic [4:0] rd_EXE;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       rs1use_ID;
    logic       rs2use_ID;
    logic       mdu_start;
    logic       mdu_abort;
    logic       stall_req;
    logic       result_valid;
    logic       pending_valid;
    logic [4:0] rd_pending;
    logic       raw_stall_ID;
    logic       fwd_mdu_ID;

    modport master (
        output issue_valid_EXE, op_is_div_EXE, divisor_zero_EXE, kill_EXE, rd_EXE,
               rs1_ID, rs2_ID, rs1use_ID, rs2use_ID,
        input  mdu_start, mdu_abort, stall_req, result_valid, pending_valid,
               rd_pending, raw_stall_ID, fwd_mdu_ID
    );

    modport slave (
        input  issue_valid_EXE, op_is_div_EXE, divisor_zero_EXE, kill_EXE, rd_EXE,
               rs1_ID, rs2_ID, rs1use_ID, rs2use_ID,
        output mdu_start, mdu_abort, stall_req, result_valid, pending_valid,
               rd_pending, raw_stall_ID, fwd_mdu_ID
    );
endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter used to time the MDU latency. Stops at zero.
module mdu_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    // Clear wins over load, load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (load)              cnt <= load_val;
        else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mdu_issue_ctrl.sv
// Sequencing controller for the iterative MDU in EXE: starts the unit,
// times its latency, stalls the pipe while busy and tracks the pending
// destination register for ID-stage RAW stall / forward decisions.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    mdu_issue_ctrl_if.slave    bus
);
    // Counter preload excludes the accept cycle and the DONE cycle.
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);

    mdu_state_e state_q, state_d;
    logic       accept, kill_act, cnt_zero;
    logic       cnt_load, cnt_dec, cnt_clr;
    logic       pend_q;
    logic [4:0] rd_q;
    logic       match;

    // rst_n gates accept so the start/stall outputs drop during reset
    // even while an instruction is still presented in EXE.
    assign accept   = rst_n & (state_q == IDLE) & bus.issue_valid_EXE & ~bus.kill_EXE;
    assign kill_act = bus.kill_EXE & (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and counter control; a kill overrides every transition.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (bus.op_is_div_EXE && bus.divisor_zero_EXE) begin
                    state_d = DONE;
                end else begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
            end
            RUN:  if (cnt_zero) state_d = DONE;
                  else          cnt_dec = 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_act) begin
            state_d  = IDLE;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
            cnt_clr  = 1'b1;
        end
    end

    mdu_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (bus.op_is_div_EXE ? DIV_LD : MUL_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Pending-writeback scoreboard; x0 writes never become pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            rd_q   <= '0;
        end else if (kill_act) begin
            pend_q <= 1'b0;
        end else if (accept) begin
            pend_q <= (bus.rd_EXE != 5'd0);
            if (bus.rd_EXE != 5'd0) rd_q <= bus.rd_EXE;
        end else if (state_q == DONE) begin
            pend_q <= 1'b0;
        end
    end

    assign match = pend_q & ((bus.rs1use_ID & (bus.rs1_ID == rd_q)) |
                             (bus.rs2use_ID & (bus.rs2_ID == rd_q)));

    assign bus.mdu_start     = accept;
    assign bus.mdu_abort     = kill_act;
    assign bus.stall_req     = accept | (state_q == RUN);
    assign bus.result_valid  = (state_q == DONE) & ~bus.kill_EXE;
    assign bus.pending_valid = pend_q;
    assign bus.rd_pending    = rd_q;
    assign bus.raw_stall_ID  = match & (state_q != DONE);
    assign bus.fwd_mdu_ID    = match & (state_q == DONE);
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: a per-cycle vector table for the
// MUL / divide-by-zero / back-to-back flow, then hand sequences for the
// long DIV, x0 destination, kill and async-reset corners.
module tb_mdu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mdu_issue_ctrl_if ifc();

    mdu_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv, dv, dz, kl;
        logic [4:0] rd, r1, r2;
        logic       u1, u2;
        logic       st, ab, sr, rv, pv, rw, fw;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic iv, logic dv, logic dz, logic kl, logic [4:0] rd,
                                logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                                logic st, logic ab, logic sr, logic rv, logic pv,
                                logic rw, logic fw);
        vec_t v;
        v.iv = iv; v.dv = dv; v.dz = dz; v.kl = kl; v.rd = rd;
        v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
        v.st = st; v.ab = ab; v.sr = sr; v.rv = rv; v.pv = pv; v.rw = rw; v.fw = fw;
        return v;
    endfunction

    task automatic chk(string nm, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drv(logic iv, logic dv, logic dz, logic kl, logic [4:0] rd,
                       logic [4:0] r1, logic u1, logic [4:0] r2, logic u2);
        ifc.issue_valid_EXE  = iv;
        ifc.op_is_div_EXE    = dv;
        ifc.divisor_zero_EXE = dz;
        ifc.kill_EXE         = kl;
        ifc.rd_EXE           = rd;
        ifc.rs1_ID           = r1;
        ifc.rs1use_ID        = u1;
        ifc.rs2_ID           = r2;
        ifc.rs2use_ID        = u2;
    endtask

    task automatic chk_all0(string tag);
        chk({tag, ".start"}, 5'(ifc.mdu_start), 5'd0);
        chk({tag, ".abort"}, 5'(ifc.mdu_abort), 5'd0);
        chk({tag, ".stall"}, 5'(ifc.stall_req), 5'd0);
        chk({tag, ".rv"},    5'(ifc.result_valid), 5'd0);
        chk({tag, ".pv"},    5'(ifc.pending_valid), 5'd0);
        chk({tag, ".rdp"},   ifc.rd_pending, 5'd0);
        chk({tag, ".raw"},   5'(ifc.raw_stall_ID), 5'd0);
        chk({tag, ".fwd"},   5'(ifc.fwd_mdu_ID), 5'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rv_seen;

        // Row = one cycle: inputs, then expected start/abort/stall/rv/pv/raw/fwd.
        tbl[0] = mk(0,0,0,0,5'd0, 5'd0,0,5'd0,0,  0,0,0,0,0,0,0);
        tbl[1] = mk(1,0,0,0,5'd5, 5'd5,1,5'd0,0,  1,0,1,0,0,0,0);
        tbl[2] = mk(1,0,0,0,5'd5, 5'd5,1,5'd0,0,  0,0,1,0,1,1,0);
        tbl[3] = mk(1,0,0,0,5'd5, 5'd5,1,5'd0,0,  0,0,1,0,1,1,0);
        tbl[4] = mk(1,0,0,0,5'd5, 5'd5,1,5'd0,0,  0,0,1,0,1,1,0);
        tbl[5] = mk(1,1,1,0,5'd3, 5'd5,1,5'd3,1,  0,0,0,1,1,0,1);
        tbl[6] = mk(1,1,1,0,5'd3, 5'd5,1,5'd3,1,  1,0,1,0,0,0,0);
        tbl[7] = mk(0,0,0,0,5'd0, 5'd5,1,5'd3,1,  0,0,0,1,1,0,1);
        tbl[8] = mk(0,0,0,0,5'd0, 5'd0,0,5'd0,0,  0,0,0,0,0,0,0);

        // Reset with an instruction presented: everything must stay low.
        drv(1,0,0,0,5'd5, 5'd5,1,5'd0,0);
        #3;
        chk_all0("reset");
        step();
        drv(0,0,0,0,5'd0, 5'd0,0,5'd0,0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            drv(tbl[i].iv, tbl[i].dv, tbl[i].dz, tbl[i].kl, tbl[i].rd,
                tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2);
            #3;
            chk($sformatf("tbl%0d.start", i), 5'(ifc.mdu_start),     5'(tbl[i].st));
            chk($sformatf("tbl%0d.abort", i), 5'(ifc.mdu_abort),     5'(tbl[i].ab));
            chk($sformatf("tbl%0d.stall", i), 5'(ifc.stall_req),     5'(tbl[i].sr));
            chk($sformatf("tbl%0d.rv", i),    5'(ifc.result_valid),  5'(tbl[i].rv));
            chk($sformatf("tbl%0d.pv", i),    5'(ifc.pending_valid), 5'(tbl[i].pv));
            chk($sformatf("tbl%0d.raw", i),   5'(ifc.raw_stall_ID),  5'(tbl[i].rw));
            chk($sformatf("tbl%0d.fwd", i),   5'(ifc.fwd_mdu_ID),    5'(tbl[i].fw));
            step();
        end

        // DIV rd=7 with ID reading x7: stall through +32, forward at +33.
        for (int k = 0; k <= 34; k++) begin
            drv(k < 33, 1, 0, 0, 5'd7, 5'd7, 1, 5'd0, 0);
            #3;
            if (k == 0) begin
                chk("div.start", 5'(ifc.mdu_start), 5'd1);
                chk("div.raw0",  5'(ifc.raw_stall_ID), 5'd0);
            end else if (k <= 32) begin
                chk($sformatf("div.raw%0d", k), 5'(ifc.raw_stall_ID), 5'd1);
                chk($sformatf("div.rv%0d", k),  5'(ifc.result_valid), 5'd0);
            end else if (k == 33) begin
                chk("div.fwd",   5'(ifc.fwd_mdu_ID),   5'd1);
                chk("div.raw33", 5'(ifc.raw_stall_ID), 5'd0);
                chk("div.rv33",  5'(ifc.result_valid), 5'd1);
                chk("div.stall", 5'(ifc.stall_req),    5'd0);
                chk("div.rdp",   ifc.rd_pending,       5'd7);
            end else begin
                chk("div.pv_clr", 5'(ifc.pending_valid), 5'd0);
            end
            step();
        end

        // DIV rd=0: nothing pending, no hazards, latency unchanged.
        for (int k = 0; k <= 34; k++) begin
            drv(k < 33, 1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 1);
            #3;
            chk($sformatf("x0.rv%0d", k), 5'(ifc.result_valid), 5'(k == 33));
            chk($sformatf("x0.pv%0d", k), 5'(ifc.pending_valid), 5'd0);
            chk($sformatf("x0.hz%0d", k), 5'(ifc.raw_stall_ID | ifc.fwd_mdu_ID), 5'd0);
            step();
        end

        // Kill at accept+5 of a DIV.
        rv_seen = 0;
        for (int k = 0; k <= 45; k++) begin
            drv(k <= 5, 1, 0, k == 5, 5'd9, 5'd0, 0, 5'd0, 0);
            #3;
            if (ifc.result_valid) rv_seen++;
            if (k == 5) chk("kill.abort", 5'(ifc.mdu_abort), 5'd1);
            if (k == 6) begin
                chk("kill.pv",     5'(ifc.pending_valid), 5'd0);
                chk("kill.stall",  5'(ifc.stall_req),     5'd0);
                chk("kill.abort1", 5'(ifc.mdu_abort),     5'd0);
            end
            step();
        end
        chk("kill.rv_never", 5'(rv_seen), 5'd0);

        // Kill in IDLE: no accept, no abort, and no RUN afterwards.
        drv(1,0,0,1,5'd4, 5'd0,0,5'd0,0);
        #3;
        chk("kidle.start", 5'(ifc.mdu_start), 5'd0);
        chk("kidle.abort", 5'(ifc.mdu_abort), 5'd0);
        step();
        drv(0,0,0,0,5'd0, 5'd0,0,5'd0,0);
        #3;
        chk("kidle.stall", 5'(ifc.stall_req), 5'd0);
        step();

        // Kill on the RUN cycle with cnt==0 beats the DONE transition.
        for (int k = 0; k <= 4; k++) begin
            drv(k <= 3, 0, 0, k == 3, 5'd6, 5'd0, 0, 5'd0, 0);
            #3;
            if (k == 3) chk("kz.abort", 5'(ifc.mdu_abort), 5'd1);
            if (k == 4) chk("kz.rv",    5'(ifc.result_valid), 5'd0);
            step();
        end

        // Kill during DONE masks result_valid.
        for (int k = 0; k <= 5; k++) begin
            drv(k <= 3, 0, 0, k == 4, 5'd6, 5'd0, 0, 5'd0, 0);
            #3;
            if (k == 4) begin
                chk("kd.rv",    5'(ifc.result_valid), 5'd0);
                chk("kd.abort", 5'(ifc.mdu_abort),    5'd1);
            end
            if (k == 5) chk("kd.pv", 5'(ifc.pending_valid), 5'd0);
            step();
        end

        // Async reset mid-RUN, then a fresh MUL with full latency.
        drv(1,0,0,0,5'd8, 5'd0,0,5'd0,0);
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk_all0("arst");
        step();
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            drv(k < 4, 0, 0, 0, 5'd9, 5'd0, 0, 5'd0, 0);
            #3;
            if (k == 0) chk("arst.start", 5'(ifc.mdu_start), 5'd1);
            chk($sformatf("arst.rv%0d", k), 5'(ifc.result_valid), 5'(k == 4));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequencing controller for the iterative multiply/divide unit (MDU) in the EXE stage of the 5-stage RV32 pipeline.
- Accepts an MDU instruction from EXE, starts the MDU, and counts its latency.
- Asks the hazard detection unit to hold IF/ID/EXE and bubble EXE->MEM while the MDU is busy.
- Tracks the pending destination register, so RAW hazards in ID against the MDU result are stalled, then forwarded on the completion cycle.

Parameters:
- MUL_LAT, 4, total cycles from issue to result for MUL* ops. Must be >= 2.
- DIV_LAT, 33, total cycles from issue to result for DIV*/REM* ops. Must be >= 2.
- CNT_W, 6, down-counter width. Must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid_EXE  in  1  MDU-class instruction present in EXE.
- op_is_div_EXE  in  1  1 = DIV/DIVU/REM/REMU, 0 = MUL*.
- divisor_zero_EXE  in  1  rs2 operand value == 0 (division fast path).
- kill_EXE  in  1  EXE instruction squashed (trap/redirect); aborts any operation.
- rd_EXE  in  5  destination register of the EXE instruction.
- rs1_ID, rs2_ID  in  5 each  ID source registers.
- rs1use_ID, rs2use_ID  in  1 each  ID source-use flags.
- mdu_start  out  1  one-cycle start pulse to the MDU datapath.
- mdu_abort  out  1  one-cycle abort pulse to the MDU datapath.
- stall_req  out  1  to hazard unit: hold PC/FD/DE, flush EM.
- result_valid  out  1  MDU result valid; EM register latches it this cycle.
- pending_valid  out  1  an MDU writeback is outstanding.
- rd_pending  out  5  destination register of the outstanding op.
- raw_stall_ID  out  1  ID reads rd_pending while the op is not yet done.
- fwd_mdu_ID  out  1  ID reads rd_pending on the DONE cycle; select the MDU result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, pending_valid=0, rd_pending=0.
  - All outputs 0, regardless of the clock.
- States: IDLE, RUN, DONE.
- accept = (state==IDLE) & issue_valid_EXE & ~kill_EXE. This is combinational.
- Outputs:
  - mdu_start = accept.
  - stall_req = accept | (state==RUN).
  - result_valid = (state==DONE).
- Transitions from IDLE on accept:
  - If op_is_div_EXE & divisor_zero_EXE: go to DONE next cycle. Total latency 1.
  - Otherwise: go to RUN, with cnt <= (op_is_div_EXE ? DIV_LAT : MUL_LAT) - 2.
- RUN:
  - If cnt==0, go to DONE.
  - Otherwise cnt <= cnt-1.
  - With accept at cycle T, result_valid is high exactly at cycle T+LAT.
- DONE: lasts one cycle and always returns to IDLE.
  - stall_req=0 in DONE, so the pipeline advances and the completed instruction moves to MEM.
  - A new MDU instruction arriving in EXE is accepted no earlier than the following IDLE cycle. There is no back-to-back accept in DONE.
- Scoreboard:
  - On accept with rd_EXE!=0: pending_valid<=1 and rd_pending<=rd_EXE.
  - On accept with rd_EXE==0: pending_valid stays 0.
  - pending_valid is cleared on leaving DONE.
- ID hazard detection:
  - match = pending_valid & ((rs1use_ID & rs1_ID==rd_pending) | (rs2use_ID & rs2_ID==rd_pending)).
  - raw_stall_ID = match & (state!=DONE).
  - fwd_mdu_ID = match & (state==DONE).
- Kill handling:
  - kill_EXE in RUN or DONE: next state IDLE, cnt<=0, pending_valid<=0.
  - mdu_abort=1 for that cycle.
  - result_valid is forced to 0 in the kill cycle.
  - kill_EXE in IDLE: nothing is accepted, and there is no abort pulse.
  - kill_EXE takes priority over every transition, including RUN with cnt==0.
- issue_valid_EXE while in RUN is the held instruction itself; it is ignored.
- Async reset asserted mid-RUN discards the op. No abort pulse is required; the MDU datapath resets on the same rst_n.

Decomposition:
- Shared package mdu_pkg holds:
  - the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the MUL_LAT and DIV_LAT defaults;
  - the funct3 decode constants used for op_is_div.
- Natural sub-module: mdu_lat_counter, a loadable CNT_W down-counter with a zero flag and async active-low clear.

Test Plan:
- MUL issue, rd=5, at cycle 10:
  - mdu_start=1 at cycle 10.
  - stall_req=1 for cycles 10..13.
  - result_valid=1 at cycle 14 only.
  - pending_valid=0 at cycle 15.
- DIV with divisor_zero_EXE=1 at cycle 20:
  - stall_req=1 at cycle 20.
  - DONE and result_valid=1 at cycle 21.
  - No RUN state is entered.
- DIV issue, rd=7, with ID rs1=7, rs1use=1:
  - raw_stall_ID=1 from accept+1 through accept+32.
  - fwd_mdu_ID=1 at accept+33.
  - raw_stall_ID=0 at accept+33.
- Same as the DIV case but with rd=0:
  - pending_valid stays 0.
  - raw_stall_ID and fwd_mdu_ID stay 0.
  - Latency is still 33 cycles.
- kill_EXE asserted at accept+5 of a DIV:
  - mdu_abort=1 that cycle.
  - state=IDLE and pending_valid=0 the next cycle.
  - result_valid is never asserted.
- rst_n dropped mid-RUN, between clock edges:
  - All outputs go to 0 immediately.
  - After release, a new MUL completes with the full MUL_LAT latency.
